// File: rtl/coin_detect.sv
// coin_detect: sync, debounce and qualify coin-slot sensors into one-cycle coin codes.
// Define COINDET_STATS_EN to add saturating accepted/rejected counters.
module coin_detect #(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] sense,
  input  logic       hold,
  output logic [1:0] coin,
  output logic       coin_valid,
  output logic       reject
`ifdef COINDET_STATS_EN
  ,
  output logic [7:0] accepted_cnt,
  output logic [7:0] rejected_cnt
`endif
);
  typedef enum logic [2:0] {IDLE, QUAL, EMIT, REJ, RELEASE} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE - 1);
  state_t           state, state_n;
  logic [2:0]       s1, s2, pat, pat_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       coin_n;
  logic             valid_n, rej_n, one_hot;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      s1         <= 3'b000;
      s2         <= 3'b000;
      state      <= IDLE;
      cnt        <= '0;
      pat        <= 3'b000;
      coin       <= 2'b11;
      coin_valid <= 1'b0;
      reject     <= 1'b0;
    end else begin
      s1         <= sense;
      s2         <= s1;
      state      <= state_n;
      cnt        <= cnt_n;
      pat        <= pat_n;
      coin       <= coin_n;
      coin_valid <= valid_n;
      reject     <= rej_n;
    end
  assign one_hot = (pat == 3'b001) || (pat == 3'b010) || (pat == 3'b100);
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pat_n   = pat;
    coin_n  = 2'b11;
    valid_n = 1'b0;
    rej_n   = 1'b0;
    case (state)
      IDLE:
        if (s2 != 3'b000) begin
          pat_n   = s2;
          cnt_n   = '0;
          state_n = QUAL;
        end
      QUAL:
        if (s2 != pat) state_n = IDLE;
        else if (cnt == LAST) begin
          if (one_hot && !hold) begin
            state_n = EMIT;
            coin_n  = pat[2] ? 2'b10 : pat[1] ? 2'b01 : 2'b00;
            valid_n = 1'b1;
          end else begin
            state_n = REJ;
            rej_n   = 1'b1;
          end
        end else cnt_n = cnt + CNT_W'(1);
      EMIT, REJ: begin
        cnt_n   = '0;
        state_n = RELEASE;
      end
      RELEASE:
        if (s2 != 3'b000) cnt_n = '0;
        else if (cnt == LAST) state_n = IDLE;
        else cnt_n = cnt + CNT_W'(1);
      default: state_n = IDLE;
    endcase
  end
`ifdef COINDET_STATS_EN
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      accepted_cnt <= 8'd0;
      rejected_cnt <= 8'd0;
    end else begin
      accepted_cnt <= (valid_n && accepted_cnt != 8'hff) ? accepted_cnt + 8'd1 : accepted_cnt;
      rejected_cnt <= (rej_n && rejected_cnt != 8'hff) ? rejected_cnt + 8'd1 : rejected_cnt;
    end
`endif
endmodule

// File: tb/tb_coin_detect.sv
// tb_coin_detect: directed vector table plus reset and back-to-back sequences for coin_detect.
module tb_coin_detect;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] sense = 3'b000;
  logic       hold = 1'b0;
  logic [1:0] coin;
  logic       coin_valid, reject;
`ifdef COINDET_STATS_EN
  logic [7:0] accepted_cnt, rejected_cnt;
  int         acc_m = 0, rej_m = 0;
`endif
  int tests = 0, fails = 0;
  coin_detect dut (
    .clock(clock),
    .reset(reset),
    .sense(sense),
    .hold(hold),
    .coin(coin),
    .coin_valid(coin_valid),
    .reject(reject)
`ifdef COINDET_STATS_EN
    ,
    .accepted_cnt(accepted_cnt),
    .rejected_cnt(rejected_cnt)
`endif
  );
  always #5 clock = ~clock;
  typedef struct {
    logic [2:0] sense;
    logic       hold;
    int         on;
    int         n_valid;
    int         n_rej;
    logic [1:0] code;
    int         at;
  } vec_t;
  vec_t v[10];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic run(input logic [2:0] s, input logic h, input int on, input int total,
                     output int nv, output int nr, output int first, output int bad,
                     output logic [1:0] code);
    nv = 0; nr = 0; first = 0; bad = 0; code = 2'b11;
    hold = h;
    for (int k = 1; k <= total; k++) begin
      sense = (k <= on) ? s : 3'b000;
      @(posedge clock);
      #1;
      if (coin_valid === 1'b1) begin
        nv++;
        code = coin;
        if (first == 0) first = k;
      end
      if (reject === 1'b1) begin
        nr++;
        if (first == 0) first = k;
      end
      if (coin_valid === 1'b1 && reject === 1'b1) bad++;
      if (coin_valid !== 1'b1 && coin !== 2'b11) bad++;
      if (coin_valid === 1'b1 && coin === 2'b11) bad++;
    end
    hold = 1'b0;
  endtask
  initial begin
    int nv, nr, first, bad;
    logic [1:0] code;
    v[0] = '{3'b001, 1'b0, 20, 1, 0, 2'b00, 7};
    v[1] = '{3'b010, 1'b0, 20, 1, 0, 2'b01, 7};
    v[2] = '{3'b100, 1'b0, 20, 1, 0, 2'b10, 7};
    v[3] = '{3'b001, 1'b0,  2, 0, 0, 2'b11, 0};
    v[4] = '{3'b011, 1'b0, 20, 0, 1, 2'b11, 7};
    v[5] = '{3'b100, 1'b1, 20, 0, 1, 2'b11, 7};
    v[6] = '{3'b111, 1'b0, 20, 0, 1, 2'b11, 7};
    v[7] = '{3'b001, 1'b1, 20, 0, 1, 2'b11, 7};
    v[8] = '{3'b001, 1'b0,  5, 1, 0, 2'b00, 7};
    v[9] = '{3'b010, 1'b0,  4, 0, 0, 2'b11, 0};
    repeat (2) @(posedge clock);
    #1;
    check("reset_coin", coin, 2'b11);
    check("reset_valid", coin_valid, 1'b0);
    check("reset_reject", reject, 1'b0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 10; i++) begin
      run(v[i].sense, v[i].hold, v[i].on, 40, nv, nr, first, bad, code);
      check($sformatf("v%0d_valid_count", i), nv, v[i].n_valid);
      check($sformatf("v%0d_reject_count", i), nr, v[i].n_rej);
      check($sformatf("v%0d_coin_code", i), code, v[i].code);
      check($sformatf("v%0d_pulse_cycle", i), first, v[i].at);
      check($sformatf("v%0d_invariants", i), bad, 0);
`ifdef COINDET_STATS_EN
      acc_m += v[i].n_valid;
      rej_m += v[i].n_rej;
      check($sformatf("v%0d_accepted_cnt", i), accepted_cnt, acc_m);
      check($sformatf("v%0d_rejected_cnt", i), rejected_cnt, rej_m);
`endif
    end
    run(3'b001, 1'b0, 20, 32, nv, nr, first, bad, code);
    check("b2b_first_count", nv, 1);
    run(3'b001, 1'b0, 20, 40, nv, nr, first, bad, code);
    check("b2b_second_count", nv, 1);
    check("b2b_second_cycle", first, 7);
    check("b2b_invariants", bad, 0);
    sense = 3'b001;
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("midqual_reset_coin", coin, 2'b11);
    check("midqual_reset_valid", coin_valid, 1'b0);
    check("midqual_reset_reject", reject, 1'b0);
`ifdef COINDET_STATS_EN
    check("midqual_reset_accepted", accepted_cnt, 0);
    check("midqual_reset_rejected", rejected_cnt, 0);
`endif
    sense = 3'b000;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    run(3'b000, 1'b0, 0, 20, nv, nr, first, bad, code);
    check("post_reset_valid", nv, 0);
    check("post_reset_reject", nr, 0);
    check("post_reset_invariants", bad, 0);
    run(3'b100, 1'b0, 20, 40, nv, nr, first, bad, code);
    check("post_reset_coin_code", code, 2'b10);
    check("post_reset_cycle", first, 7);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
